// File: rtl/force_cache_accum.sv
// Per-cell force cache: accumulates partial-force packets per particle with saturating
// read-modify-write, then drains all entries in ID order while clearing them.
module force_cache_accum #(
  parameter int unsigned DATA_WIDTH        = 32,
  parameter int unsigned PARTICLE_ID_WIDTH = 7,
  parameter int unsigned FORCE_CACHE_WIDTH = 3 * DATA_WIDTH,
  parameter int unsigned FORCE_DATA_WIDTH  = FORCE_CACHE_WIDTH + PARTICLE_ID_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [FORCE_DATA_WIDTH-1:0]  in_data,
  input  logic                         in_valid,
  input  logic                         rd_start,
  output logic [FORCE_CACHE_WIDTH-1:0] out_data,
  output logic [PARTICLE_ID_WIDTH-1:0] out_id,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         busy,
  output logic                         done,
  output logic                         err_drop,
  output logic                         sat_flag
);

  localparam int unsigned DEPTH = 2 ** PARTICLE_ID_WIDTH;

  localparam logic [1:0] S_CLEAR = 2'd0;
  localparam logic [1:0] S_IDLE  = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  logic [1:0] state, state_nxt;

  logic [FORCE_CACHE_WIDTH-1:0] mem [DEPTH];
  logic [FORCE_CACHE_WIDTH-1:0] rd_q;
  logic                         rd_en;
  logic [PARTICLE_ID_WIDTH-1:0] rd_addr;
  logic                         wr_en;
  logic [PARTICLE_ID_WIDTH-1:0] wr_addr;
  logic [FORCE_CACHE_WIDTH-1:0] wr_data;

  logic [PARTICLE_ID_WIDTH-1:0] clr_id;
  logic [PARTICLE_ID_WIDTH-1:0] rd_id;
  logic                         rd_pend;

  logic                         s1_valid, s2_valid, s3_valid;
  logic [PARTICLE_ID_WIDTH-1:0] s1_pid, s2_pid, s3_pid;
  logic [FORCE_CACHE_WIDTH-1:0] s1_force, s2_sum, s3_sum;

  logic [FORCE_CACHE_WIDTH-1:0] base_c, sum_c;
  logic [2:0]                   sat_c;

  logic [PARTICLE_ID_WIDTH-1:0] in_pid;
  logic [FORCE_CACHE_WIDTH-1:0] in_force;
  logic accept_in, beat_acc, last_beat, load_out, rd_last, flush_to_drain;

  assign in_pid         = in_data[PARTICLE_ID_WIDTH-1:0];
  assign in_force       = in_data[FORCE_DATA_WIDTH-1:PARTICLE_ID_WIDTH];
  assign accept_in      = in_valid && (state == S_IDLE);
  assign beat_acc       = out_valid && out_ready;
  assign last_beat      = beat_acc && (out_id == PARTICLE_ID_WIDTH'(DEPTH - 1));
  assign rd_last        = (rd_id == PARTICLE_ID_WIDTH'(DEPTH - 1));
  assign load_out       = (state == S_DRAIN) && rd_pend && (!out_valid || out_ready);
  assign flush_to_drain = (state == S_FLUSH) && (state_nxt == S_DRAIN);

  // Signed add clamped to the representable range; MSB of the result flags saturation.
  function automatic logic [DATA_WIDTH:0] sat_add(input logic [DATA_WIDTH-1:0] a,
                                                   input logic [DATA_WIDTH-1:0] b);
    logic [DATA_WIDTH-1:0] s;
    logic                  ovf;
    s   = a + b;
    ovf = (a[DATA_WIDTH-1] == b[DATA_WIDTH-1]) && (s[DATA_WIDTH-1] != a[DATA_WIDTH-1]);
    if (ovf) begin
      s = a[DATA_WIDTH-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}} : {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end
    return {ovf, s};
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_CLEAR;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_CLEAR: if (clr_id == PARTICLE_ID_WIDTH'(DEPTH - 1)) state_nxt = S_IDLE;
      S_IDLE:  if (rd_start) state_nxt = S_FLUSH;
      S_FLUSH: if (!s1_valid && !s2_valid) state_nxt = S_DRAIN;
      S_DRAIN: if (last_beat) state_nxt = S_IDLE;
      default: state_nxt = S_CLEAR;
    endcase
  end

  // Sums still in flight (s2 not yet written, s3 written on the same edge as our read)
  // take priority over the RAM copy; s2 is the newer of the two.
  always_comb begin
    base_c = rd_q;
    if (s3_valid && (s3_pid == s1_pid)) base_c = s3_sum;
    if (s2_valid && (s2_pid == s1_pid)) base_c = s2_sum;
    sum_c = '0;
    sat_c = '0;
    for (int i = 0; i < 3; i++) begin
      {sat_c[i], sum_c[i*DATA_WIDTH +: DATA_WIDTH]} =
        sat_add(base_c[i*DATA_WIDTH +: DATA_WIDTH], s1_force[i*DATA_WIDTH +: DATA_WIDTH]);
    end
  end

  always_comb begin
    rd_en   = 1'b0;
    rd_addr = in_pid;
    if (accept_in) begin
      rd_en = 1'b1;
    end else if (flush_to_drain) begin
      rd_en   = 1'b1;
      rd_addr = '0;
    end else if (load_out && !rd_last) begin
      rd_en   = 1'b1;
      rd_addr = rd_id + PARTICLE_ID_WIDTH'(1);
    end
  end

  always_comb begin
    wr_en   = 1'b0;
    wr_addr = s2_pid;
    wr_data = s2_sum;
    if (state == S_CLEAR) begin
      wr_en   = 1'b1;
      wr_addr = clr_id;
      wr_data = '0;
    end else if (beat_acc) begin
      wr_en   = 1'b1;
      wr_addr = out_id;
      wr_data = '0;
    end else if (s2_valid) begin
      wr_en = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_q <= mem[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      s3_valid  <= 1'b0;
      s1_pid    <= '0;
      s2_pid    <= '0;
      s3_pid    <= '0;
      s1_force  <= '0;
      s2_sum    <= '0;
      s3_sum    <= '0;
      clr_id    <= '0;
      rd_id     <= '0;
      rd_pend   <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_id    <= '0;
      done      <= 1'b0;
      err_drop  <= 1'b0;
      sat_flag  <= 1'b0;
      busy      <= 1'b1;
    end else begin
      s1_valid <= accept_in;
      s1_pid   <= in_pid;
      s1_force <= in_force;
      s2_valid <= s1_valid;
      s2_pid   <= s1_pid;
      s2_sum   <= sum_c;
      s3_valid <= s2_valid;
      s3_pid   <= s2_pid;
      s3_sum   <= s2_sum;
      busy     <= (state_nxt != S_IDLE);
      done     <= last_beat;
      if (state == S_CLEAR) clr_id <= clr_id + PARTICLE_ID_WIDTH'(1);
      if (in_valid && (state != S_IDLE)) err_drop <= 1'b1;
      if (s1_valid && (|sat_c)) sat_flag <= 1'b1;
      // Output beat register: prefetched RAM word moves in when the slot is free.
      if (flush_to_drain) begin
        rd_pend <= 1'b1;
        rd_id   <= '0;
      end else if (load_out) begin
        out_valid <= 1'b1;
        out_data  <= rd_q;
        out_id    <= rd_id;
        rd_id     <= rd_id + PARTICLE_ID_WIDTH'(1);
        rd_pend   <= !rd_last;
      end else if (beat_acc) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_force_cache_accum.sv
// Directed bench for force_cache_accum: clear, accumulate with forwarding, saturation,
// stalled drains, drops during drain and reset in the middle of a drain.
module tb_force_cache_accum;

  localparam int unsigned DW   = 32;
  localparam int unsigned PW   = 7;
  localparam int unsigned FCW  = 3 * DW;
  localparam int unsigned FDW  = FCW + PW;
  localparam int unsigned NENT = 2 ** PW;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [FDW-1:0] in_data;
  logic           in_valid;
  logic           rd_start;
  logic [FCW-1:0] out_data;
  logic [PW-1:0]  out_id;
  logic           out_valid;
  logic           out_ready;
  logic           busy, done, err_drop, sat_flag;

  logic [FCW-1:0] exp_mem [NENT];
  int checks = 0;
  int errors = 0;

  force_cache_accum dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .rd_start(rd_start), .out_data(out_data), .out_id(out_id), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .done(done), .err_drop(err_drop),
    .sat_flag(sat_flag)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, expv);
    end
  endtask

  function automatic logic [FDW-1:0] pkt(input int pid, input logic [31:0] fx,
                                         input logic [31:0] fy, input logic [31:0] fz);
    return {fz, fy, fx, PW'(pid)};
  endfunction

  // Entered and left at a negedge.
  task automatic send(input logic [FDW-1:0] d);
    in_data  = d;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic clear_model();
    for (int i = 0; i < int'(NENT); i++) exp_mem[i] = '0;
  endtask

  task automatic wait_clear(input string tag);
    int cnt = 0;
    while (busy && cnt < 1000) begin
      cnt++;
      @(negedge clk);
    end
    check_eq(tag, 128'(cnt), 128'(NENT));
  endtask

  // Full drain checked against exp_mem; optional input in the rd_start cycle and an
  // optional injected (to-be-dropped) beat at drain cycle inj_cyc.
  task automatic drain(input string tag, input bit rnd, input bit with_v,
                       input logic [FDW-1:0] with_d, input int inj_cyc);
    int nxt = 0;
    int dones = 0;
    int cyc = 0;
    bit stall = 1'b0;
    logic [FCW-1:0] hd;
    logic [PW-1:0]  hi;
    rd_start  = 1'b1;
    in_valid  = with_v;
    in_data   = with_d;
    out_ready = 1'b1;
    @(negedge clk);
    rd_start = 1'b0;
    in_valid = 1'b0;
    while (nxt < int'(NENT) && cyc < 3000) begin
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      in_valid  = (cyc == inj_cyc);
      in_data   = pkt(3, 32'd99, 32'd99, 32'd99);
      if (out_valid) begin
        if (stall) begin
          check_eq({tag, "_stall_data"}, 128'(out_data), 128'(hd));
          check_eq({tag, "_stall_id"}, 128'(out_id), 128'(hi));
        end
        if (out_ready) begin
          check_eq({tag, "_id"}, 128'(out_id), 128'(nxt));
          check_eq({tag, "_data"}, 128'(out_data), 128'(exp_mem[nxt]));
          nxt++;
          stall = 1'b0;
        end else begin
          stall = 1'b1;
          hd    = out_data;
          hi    = out_id;
        end
      end
      @(negedge clk);
      cyc++;
      if (done) dones++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (done) dones++;
    end
    check_eq({tag, "_beats"}, 128'(nxt), 128'(NENT));
    check_eq({tag, "_done_pulses"}, 128'(dones), 128'(1));
    check_eq({tag, "_valid_after"}, 128'(out_valid), 128'(0));
    check_eq({tag, "_busy_after"}, 128'(busy), 128'(0));
    clear_model();
  endtask

  initial begin
    int beats;
    rst_n     = 1'b0;
    in_data   = '0;
    in_valid  = 1'b0;
    rd_start  = 1'b0;
    out_ready = 1'b0;
    clear_model();

    // 1: reset values, CLEAR length, zero drain
    repeat (3) @(negedge clk);
    check_eq("rst_out_valid", 128'(out_valid), 128'(0));
    check_eq("rst_out_data", 128'(out_data), 128'(0));
    check_eq("rst_out_id", 128'(out_id), 128'(0));
    check_eq("rst_done", 128'(done), 128'(0));
    check_eq("rst_err_drop", 128'(err_drop), 128'(0));
    check_eq("rst_sat_flag", 128'(sat_flag), 128'(0));
    check_eq("rst_busy", 128'(busy), 128'(1));
    rst_n = 1'b1;
    wait_clear("clear_cycles");
    drain("t1", 1'b0, 1'b0, '0, -1);

    // 2: three back-to-back updates to one pid
    send(pkt(5, 32'd1, 32'd0, 32'd0));
    send(pkt(5, 32'd2, 32'd0, 32'd0));
    send(pkt(5, 32'd3, 32'd0, 32'd0));
    repeat (4) @(negedge clk);
    exp_mem[5] = {32'd0, 32'd0, 32'd6};
    drain("t2", 1'b0, 1'b0, '0, -1);

    // 3: interleaved pids (spacing 2) plus an input in the rd_start cycle
    send(pkt(1, 32'd0, 32'd10, 32'd0));
    send(pkt(2, 32'd0, 32'd10, 32'd0));
    send(pkt(1, 32'd0, 32'd10, 32'd0));
    send(pkt(2, 32'd0, 32'd10, 32'd0));
    send(pkt(1, 32'd0, 32'd10, 32'd0));
    exp_mem[1]  = {32'd0, 32'd30, 32'd0};
    exp_mem[2]  = {32'd0, 32'd20, 32'd0};
    exp_mem[20] = {32'd0, 32'd0, 32'd7};
    drain("t3", 1'b0, 1'b1, pkt(20, 32'd7, 32'd0, 32'd0), -1);
    check_eq("sat_before", 128'(sat_flag), 128'(0));
    check_eq("drop_before", 128'(err_drop), 128'(0));

    // 4: saturation both directions, per-component, then 5: stalled drain and re-drain
    send(pkt(9, 32'h7FFF_FFF0, 32'd5, 32'd0));
    send(pkt(10, 32'd0, 32'd0, 32'h8000_0010));
    send(pkt(9, 32'h0000_0020, 32'd0, 32'd0));
    send(pkt(10, 32'd0, 32'd0, 32'hFFFF_FFE0));
    repeat (4) @(negedge clk);
    check_eq("sat_flag_set", 128'(sat_flag), 128'(1));
    exp_mem[9]  = {32'd0, 32'd5, 32'h7FFF_FFFF};
    exp_mem[10] = {32'h8000_0000, 32'd0, 32'd0};
    drain("t5_rand", 1'b1, 1'b0, '0, -1);
    drain("t5_again", 1'b0, 1'b0, '0, -1);

    // 6: dropped beat during drain, then reset in the middle of a drain
    drain("t6_drop", 1'b0, 1'b0, '0, 5);
    check_eq("err_drop_set", 128'(err_drop), 128'(1));
    drain("t6_absent", 1'b0, 1'b0, '0, -1);
    send(pkt(100, 32'd1, 32'd0, 32'd0));
    send(pkt(50, 32'd0, 32'd2, 32'd0));
    repeat (3) @(negedge clk);
    rd_start  = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    rd_start = 1'b0;
    beats    = 0;
    while (!(out_valid && out_id == PW'(40)) && beats < 500) begin
      beats++;
      @(negedge clk);
    end
    check_eq("reach_beat40", 128'(out_id), 128'(40));
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("midrst_out_valid", 128'(out_valid), 128'(0));
    check_eq("midrst_busy", 128'(busy), 128'(1));
    check_eq("midrst_err_drop", 128'(err_drop), 128'(0));
    rst_n = 1'b1;
    wait_clear("midrst_clear_cycles");
    clear_model();
    drain("t6_post_rst", 1'b0, 1'b0, '0, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
